fpu_issue_scoreboard: RTL
=========================

FPU_ISSUE_SCOREBOARD -- requirements
Module: fpu_issue_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32, SHALL set the FP register count tracked by the scoreboard.
REQ-002 Parameter PIPELINE_STAGES, default 4, SHALL set the FPU pipeline depth, which is also the in-flight tracker depth.
REQ-003 Parameter X_ID_WIDTH, default 4, SHALL set the instruction ID width.
REQ-004 Ports SHALL be:
  ck  in  1  clock
  rst  in  1  reset; one clock, asynchronous, active-high
  issue_valid  in  1  core offers an instruction
  issue_ready  out  1  instruction accepted this cycle when high with issue_valid
  issue_instr  in  32  RV32F instruction word
  issue_id  in  X_ID_WIDTH  instruction tag
  flush  in  1  request pipeline drain
  fpu_stall  in  1  FPU pipeline full; freezes issue and tracking
  fpu_rst  out  1  reset to the FPU model
  fpu_enable  out  1  FPU advances and consumes fpu_instr
  fpu_instr  out  32  instruction to the FPU
  fpu_id  out  X_ID_WIDTH  tag to the FPU
  result_valid  out  1  one-cycle retire pulse
  result_id  out  X_ID_WIDTH  tag of the retiring instruction
  illegal  out  1  one-cycle pulse for an accepted, unsupported opcode
  busy  out  1  at least one tracker entry valid

Function
REQ-005 The FSM SHALL have three states: INIT, RUN and DRAIN.
REQ-006 The FSM SHALL enter INIT on reset, assert fpu_rst for exactly one cycle, then move to RUN.
REQ-007 In RUN, flush SHALL move the FSM to DRAIN.
REQ-008 In DRAIN, the FSM SHALL return to RUN on the first cycle busy is low.
REQ-009 issue_ready SHALL be high only when all of the following hold: state is RUN, flush is low, fpu_stall is low, and there is no hazard.
REQ-010 A hazard SHALL be any FP source register, or FP destination register, whose scoreboard bit is set (RAW and WAW).
REQ-011 Decode rule: LOAD-FP (0000111) SHALL write FP rd and have no FP sources.
REQ-012 Decode rule: STORE-FP (0100111) SHALL read FP rs2 and write nothing.
REQ-013 Decode rule: fused opcodes (1000011, 1000111, 1001011, 1001111) SHALL read FP rs1, rs2 and rs3 and write FP rd.
REQ-014 Decode rule: OP-FP (1010011) SHALL write X rd for funct5 10100, 11000 and 11100, and FP rd otherwise.
REQ-015 Decode rule: OP-FP SHALL read FP rs1 except for funct5 11010 and 11110.
REQ-016 Decode rule: OP-FP SHALL read FP rs2 only for funct5 00000, 00001, 00010, 00011, 00100, 00101 and 10100.
REQ-017 An accepted instruction with any other opcode SHALL pulse illegal on the next cycle, SHALL NOT reach the FPU and SHALL NOT enter the tracker.
REQ-018 An accepted legal instruction SHALL appear on fpu_instr/fpu_id with fpu_enable high on the next cycle; this is a registered, one-cycle issue latency.
REQ-019 An accepted instruction that writes FP rd SHALL set that rd's scoreboard bit on the accept edge.
REQ-020 The tracker SHALL be a PIPELINE_STAGES-entry shift register holding {valid, writes_fp, rd, id}.
REQ-021 The tracker SHALL shift once per cycle while fpu_stall is low; when fpu_stall is high, the tracker and fpu_enable SHALL hold.
REQ-022 A tracker entry leaving the last stage SHALL pulse result_valid with its id.
REQ-023 A retiring entry with writes_fp set SHALL clear its rd's scoreboard bit.
REQ-024 Retire-to-issue latency: result_valid SHALL fire PIPELINE_STAGES cycles after fpu_enable, plus any stall cycles.
REQ-025 The hazard check SHALL use the registered scoreboard, with no retire bypass; the earliest dependent accept is the cycle after the producer's result_valid.
REQ-026 When a retire clears and an accept sets the same rd in one cycle, set SHALL win.
REQ-027 fpu_enable SHALL be low in every cycle in which no instruction is issued.

Reset
REQ-028 Asynchronous reset SHALL clear the scoreboard and tracker and force state INIT.
REQ-029 During reset, fpu_rst SHALL be 1 and every other output SHALL be 0.
REQ-030 Any instruction accepted or in flight when reset asserts SHALL be discarded with no result_valid.

Structure
REQ-031 A shared package SHALL hold the opcode constants, the funct5 constants, the FSM state enum and the tracker-entry struct.
REQ-032 Decode SHALL be a combinational sub-module, fpu_instr_decode, with outputs rs1/rs2/rs3/rd FP-use flags and legal.

Verification
REQ-033 Independent back-to-back FADD.S to f1 and then f2 -> accepted on consecutive cycles; result_valid 4 cycles after each fpu_enable (PIPELINE_STAGES=4).
REQ-034 FMUL.S writing f3, then FADD.S reading f3 -> issue_ready low until result_valid of the FMUL; the FADD is accepted the following cycle.
REQ-035 fpu_stall high for 3 cycles with 2 instructions in flight -> retirements delayed exactly 3 cycles; issue_ready low throughout the stall.
REQ-036 flush with 2 instructions in flight -> state DRAIN; both retire; state returns to RUN the cycle after busy falls; no accepts during DRAIN.
REQ-037 Opcode 0110011 offered -> accepted; illegal pulses once; fpu_enable stays 0; busy stays 0.
REQ-038 rst asserted mid-flight -> all outputs 0 except fpu_rst; after release, exactly one cycle of fpu_rst, then RUN with an empty scoreboard.

Source files
------------

// File: rtl/fpu_issue_scoreboard_pkg.sv
// Shared definitions for the FP issue scoreboard: RV32F opcodes, OP-FP funct5
// selectors, control FSM states and the in-flight tracker entry layout.
package fpu_issue_scoreboard_pkg;

    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_FMADD    = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

    localparam logic [4:0] F5_FADD     = 5'b00000;
    localparam logic [4:0] F5_FSUB     = 5'b00001;
    localparam logic [4:0] F5_FMUL     = 5'b00010;
    localparam logic [4:0] F5_FDIV     = 5'b00011;
    localparam logic [4:0] F5_FSGNJ    = 5'b00100;
    localparam logic [4:0] F5_FMINMAX  = 5'b00101;
    localparam logic [4:0] F5_FCMP     = 5'b10100;
    localparam logic [4:0] F5_FCVT_W_S = 5'b11000;
    localparam logic [4:0] F5_FCVT_S_W = 5'b11010;
    localparam logic [4:0] F5_FMV_X_W  = 5'b11100;
    localparam logic [4:0] F5_FMV_W_X  = 5'b11110;

    // Tracker ids are stored at this width; X_ID_WIDTH must not exceed it.
    localparam int unsigned TRK_ID_W = 16;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic                valid;
        logic                writes_fp;
        logic [4:0]          rd;
        logic [TRK_ID_W-1:0] id;
    } trk_entry_t;

endpackage

// File: rtl/fpu_issue_scoreboard_decode.sv
// Combinational RV32F register-use decode: which FP operands an instruction
// reads, whether it writes an FP destination, and whether it is supported.
module fpu_instr_decode
    import fpu_issue_scoreboard_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] funct5,
    output logic       rs1_fp,
    output logic       rs2_fp,
    output logic       rs3_fp,
    output logic       rd_fp,
    output logic       legal
);

    always_comb begin
        rs1_fp = 1'b0;
        rs2_fp = 1'b0;
        rs3_fp = 1'b0;
        rd_fp  = 1'b0;
        legal  = 1'b0;
        case (opcode)
            OPC_LOAD_FP: begin
                legal = 1'b1;
                rd_fp = 1'b1;
            end
            OPC_STORE_FP: begin
                legal  = 1'b1;
                rs2_fp = 1'b1;
            end
            OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
                legal  = 1'b1;
                rs1_fp = 1'b1;
                rs2_fp = 1'b1;
                rs3_fp = 1'b1;
                rd_fp  = 1'b1;
            end
            OPC_OP_FP: begin
                legal  = 1'b1;
                // Compares, FCVT.W and FMV.X/FCLASS target the integer file.
                rd_fp  = !(funct5 inside {F5_FCMP, F5_FCVT_W_S, F5_FMV_X_W});
                rs1_fp = !(funct5 inside {F5_FCVT_S_W, F5_FMV_W_X});
                rs2_fp = funct5 inside {F5_FADD, F5_FSUB, F5_FMUL, F5_FDIV,
                                        F5_FSGNJ, F5_FMINMAX, F5_FCMP};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fpu_issue_scoreboard.sv
// FP issue stage: RAW/WAW scoreboard, registered issue into a fixed-latency
// FPU, and a shift-register tracker that produces the retire pulses.
module fpu_issue_scoreboard
    import fpu_issue_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned PIPELINE_STAGES = 4,
    parameter int unsigned X_ID_WIDTH      = 4
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [31:0]           issue_instr,
    input  logic [X_ID_WIDTH-1:0] issue_id,
    input  logic                  flush,
    input  logic                  fpu_stall,
    output logic                  fpu_rst,
    output logic                  fpu_enable,
    output logic [31:0]           fpu_instr,
    output logic [X_ID_WIDTH-1:0] fpu_id,
    output logic                  result_valid,
    output logic [X_ID_WIDTH-1:0] result_id,
    output logic                  illegal,
    output logic                  busy
);

    localparam int unsigned LAST = PIPELINE_STAGES - 1;

    state_e                state_q, state_d;
    logic [NUM_REGS-1:0]   sb_q, sb_d;
    trk_entry_t            trk_q [PIPELINE_STAGES];
    trk_entry_t            trk_d [PIPELINE_STAGES];
    logic                  fpu_enable_q, fpu_enable_d;
    logic [31:0]           fpu_instr_q, fpu_instr_d;
    logic [X_ID_WIDTH-1:0] fpu_id_q, fpu_id_d;
    logic                  ret_valid_q, ret_valid_d;
    logic                  ret_fp_q, ret_fp_d;
    logic [4:0]            ret_rd_q, ret_rd_d;
    logic [X_ID_WIDTH-1:0] ret_id_q, ret_id_d;
    logic                  illegal_q, illegal_d;

    logic [4:0] rs1, rs2, rs3, rd;
    logic       rs1_fp, rs2_fp, rs3_fp, rd_fp, legal;
    logic       hazard, accept, issue_fpu, busy_c;
    trk_entry_t new_entry;

    assign rd  = issue_instr[11:7];
    assign rs1 = issue_instr[19:15];
    assign rs2 = issue_instr[24:20];
    assign rs3 = issue_instr[31:27];

    fpu_instr_decode u_decode (
        .opcode (issue_instr[6:0]),
        .funct5 (issue_instr[31:27]),
        .rs1_fp (rs1_fp),
        .rs2_fp (rs2_fp),
        .rs3_fp (rs3_fp),
        .rd_fp  (rd_fp),
        .legal  (legal)
    );

    assign hazard = (rs1_fp & sb_q[rs1]) | (rs2_fp & sb_q[rs2])
                  | (rs3_fp & sb_q[rs3]) | (rd_fp & sb_q[rd]);

    assign issue_ready = (state_q == ST_RUN) & ~flush & ~fpu_stall & ~hazard;
    assign accept      = issue_valid & issue_ready;
    assign issue_fpu   = accept & legal;

    always_comb begin
        busy_c = 1'b0;
        for (int unsigned i = 0; i < PIPELINE_STAGES; i++) begin
            busy_c = busy_c | trk_q[i].valid;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_RUN;
            ST_RUN:   if (flush) state_d = ST_DRAIN;
            ST_DRAIN: if (!busy_c) state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
    end

    // Retire clears from the registered retire slot, a cycle after the pulse;
    // the accept's set is applied afterwards so it wins on the same rd.
    always_comb begin
        sb_d = sb_q;
        if (ret_valid_q && ret_fp_q) sb_d[ret_rd_q] = 1'b0;
        if (issue_fpu && rd_fp)      sb_d[rd]       = 1'b1;
    end

    always_comb begin
        new_entry           = '0;
        new_entry.valid     = issue_fpu;
        new_entry.writes_fp = issue_fpu & rd_fp;
        new_entry.rd        = issue_fpu ? rd : 5'd0;
        new_entry.id        = issue_fpu ? TRK_ID_W'(issue_id) : '0;

        trk_d        = trk_q;
        fpu_enable_d = fpu_enable_q;
        fpu_instr_d  = fpu_instr_q;
        fpu_id_d     = fpu_id_q;
        ret_valid_d  = 1'b0;
        ret_fp_d     = trk_q[LAST].writes_fp;
        ret_rd_d     = trk_q[LAST].rd;
        ret_id_d     = X_ID_WIDTH'(trk_q[LAST].id);
        illegal_d    = accept & ~legal;

        if (!fpu_stall) begin
            ret_valid_d = trk_q[LAST].valid;
            for (int unsigned i = 1; i < PIPELINE_STAGES; i++) begin
                trk_d[i] = trk_q[i-1];
            end
            trk_d[0]     = new_entry;
            fpu_enable_d = issue_fpu;
            fpu_instr_d  = issue_fpu ? issue_instr : '0;
            fpu_id_d     = issue_fpu ? issue_id : '0;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            sb_q         <= '0;
            for (int unsigned i = 0; i < PIPELINE_STAGES; i++) begin
                trk_q[i] <= '0;
            end
            fpu_enable_q <= 1'b0;
            fpu_instr_q  <= '0;
            fpu_id_q     <= '0;
            ret_valid_q  <= 1'b0;
            ret_fp_q     <= 1'b0;
            ret_rd_q     <= '0;
            ret_id_q     <= '0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sb_q         <= sb_d;
            for (int unsigned i = 0; i < PIPELINE_STAGES; i++) begin
                trk_q[i] <= trk_d[i];
            end
            fpu_enable_q <= fpu_enable_d;
            fpu_instr_q  <= fpu_instr_d;
            fpu_id_q     <= fpu_id_d;
            ret_valid_q  <= ret_valid_d;
            ret_fp_q     <= ret_fp_d;
            ret_rd_q     <= ret_rd_d;
            ret_id_q     <= ret_id_d;
            illegal_q    <= illegal_d;
        end
    end

    assign fpu_rst      = (state_q == ST_INIT);
    assign fpu_enable   = fpu_enable_q;
    assign fpu_instr    = fpu_instr_q;
    assign fpu_id       = fpu_id_q;
    assign result_valid = ret_valid_q;
    assign result_id    = ret_id_q;
    assign illegal      = illegal_q;
    assign busy         = busy_c;

endmodule
